// File: rtl/instr_fetch.sv
// Instruction fetch stage: ROM fetch FSM with external-bus arbitration and a tagged instruction buffer.
// Define IFETCH_PREFETCH_EN to add a second buffer entry filled by next-address prefetch.
module instr_fetch #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              flush,
  input  logic              bus_grant,
  input  logic [15:0]       rom_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              bus_req,
  output logic              ROM_CE,
  output logic              ROM_OE,
  output logic [ADDR_W-1:0] rom_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_LATCH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [2:0]        wait_cnt;
  logic              hit;
  logic              start_fetch;
  logic [ADDR_W-1:0] start_addr;
  logic              fill;

  // A fill only happens when the access is not being discarded the same cycle.
  assign fill = (state == S_LATCH) && !flush;

`ifdef IFETCH_PREFETCH_EN
  logic [15:0]       buf_data [2];
  logic [ADDR_W-1:0] buf_tag  [2];
  logic [1:0]        buf_v;
  logic [1:0]        way_hit;
  logic              newest;
  logic              victim;
  logic              cur_pf;
  logic              pf_arm;
  logic [ADDR_W-1:0] pf_addr;
  logic              pf_present;
  logic              demand_miss;
  logic              start_pf;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    way_hit = '0;
    for (int i = 0; i < 2; i++) begin
      way_hit[i] = buf_v[i] && (buf_tag[i] == pc);
    end
  end

  assign hit   = (state == S_IDLE) && fetch_req && (|way_hit);
  assign instr = way_hit[1] ? buf_data[1] : buf_data[0];

  // Next-address prefetch runs once per demand fill, and only when that line is not already held.
  assign pf_addr     = buf_tag[newest] + ADDR_W'(1);
  assign pf_present  = (buf_v[0] && (buf_tag[0] == pf_addr)) ||
                       (buf_v[1] && (buf_tag[1] == pf_addr));
  assign demand_miss = fetch_req && !hit;
  assign start_pf    = pf_arm && buf_v[newest] && !pf_present && !demand_miss;
  assign start_fetch = demand_miss || start_pf;
  assign start_addr  = demand_miss ? pc : pf_addr;
  assign victim      = !buf_v[0] ? 1'b0 : (!buf_v[1] ? 1'b1 : !newest);

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_v       <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_tag[0]  <= '0;
      buf_tag[1]  <= '0;
      newest      <= 1'b0;
      cur_pf      <= 1'b0;
      pf_arm      <= 1'b0;
    end else if (flush) begin
      buf_v  <= '0;
      pf_arm <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start_fetch) begin
        cur_pf <= !demand_miss;
        if (!demand_miss) pf_arm <= 1'b0;
      end
      if (fill) begin
        buf_data[victim] <= rom_data;
        buf_tag[victim]  <= fetch_addr;
        buf_v[victim]    <= 1'b1;
        newest           <= victim;
        if (!cur_pf) pf_arm <= 1'b1;
      end
    end
  end
`else
  logic [15:0]       buf_data;
  logic [ADDR_W-1:0] buf_tag;
  logic              buf_v;

  assign hit         = (state == S_IDLE) && fetch_req && buf_v && (buf_tag == pc);
  assign instr       = buf_data;
  assign start_fetch = fetch_req && !hit;
  assign start_addr  = pc;

  // NOTE: the data register is reset as well, because instr must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_v    <= 1'b0;
      buf_data <= '0;
      buf_tag  <= '0;
    end else if (flush) begin
      buf_v <= 1'b0;
    end else if (fill) begin
      buf_data <= rom_data;
      buf_tag  <= fetch_addr;
      buf_v    <= 1'b1;
    end
  end
`endif

  assign instr_valid = hit;
  assign stall       = fetch_req && !hit;

  // NOTE: state and pin registers use non-blocking assignments; reset is synchronous, active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      bus_req    <= 1'b0;
      ROM_CE     <= 1'b1;
      ROM_OE     <= 1'b1;
      rom_addr_o <= '0;
      fetch_addr <= '0;
      wait_cnt   <= '0;
    end else if (flush) begin
      state   <= S_IDLE;
      bus_req <= 1'b0;
      ROM_CE  <= 1'b1;
      ROM_OE  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_fetch) begin
            fetch_addr <= start_addr;
            bus_req    <= 1'b1;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (bus_grant) begin
            rom_addr_o <= fetch_addr;
            ROM_CE     <= 1'b0;
            ROM_OE     <= 1'b0;
            wait_cnt   <= 3'(WAIT_STATES);
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Losing the bus abandons this access; it restarts from SETUP with a fresh count.
          if (!bus_grant) begin
            ROM_CE <= 1'b1;
            ROM_OE <= 1'b1;
            state  <= S_SETUP;
          end else if (wait_cnt == 3'd1) begin
            state <= S_LATCH;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_LATCH: begin
          ROM_CE  <= 1'b1;
          ROM_OE  <= 1'b1;
          bus_req <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetches against a
// transaction-level model (buffer contents and access latency from the grant pattern).
module tb_instr_fetch;
  localparam int WS = 2;
  localparam int AW = 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] pc;
  logic          fetch_req;
  logic          flush;
  logic          bus_grant;
  logic [15:0]   rom_data;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          stall;
  logic          bus_req;
  logic          ROM_CE;
  logic          ROM_OE;
  logic [AW-1:0] rom_addr_o;

  instr_fetch #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .flush(flush),
    .bus_grant(bus_grant), .rom_data(rom_data), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .bus_req(bus_req),
    .ROM_CE(ROM_CE), .ROM_OE(ROM_OE), .rom_addr_o(rom_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one buffered line.
  bit          m_v;
  logic [15:0] m_tag;
  logic [15:0] m_data;

  // Grant level for each cycle of a miss, cycle 0 being the request cycle.
  bit gnt [0:79];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: grant always; 1: random, settling high by cycle 40; 2: withheld 4 cycles, dropped mid-WAIT.
  task automatic set_grant(input int mode);
    for (int c = 0; c < 80; c++) begin
      case (mode)
        0:       gnt[c] = 1'b1;
        1:       gnt[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 99) < 75);
        default: gnt[c] = !((c >= 1 && c <= 4) || c == 6);
      endcase
    end
  endtask

  // A ROM access completes once the bus is held for one accept cycle plus WS wait cycles in a row;
  // any break starts over. Returns the first cycle of that granted run.
  function automatic int first_run();
    for (int s = 1; s < 60; s++) begin
      bit ok = 1'b1;
      for (int j = 0; j <= WS; j++) if (!gnt[s + j]) ok = 1'b0;
      if (ok) return s;
    end
    return 60;
  endfunction

  task automatic run_miss(input logic [15:0] addr, input logic [15:0] data);
    int s;
    int v;
    s = first_run();
    v = s + WS + 2;
    for (int c = 0; c <= v; c++) begin
      pc        = addr;
      fetch_req = 1'b1;
      flush     = 1'b0;
      bus_grant = gnt[c];
      rom_data  = (c == v - 1) ? data : 16'($urandom);
      @(negedge clk);
      if (c == v) begin
        check("miss_valid", instr_valid, 1);
        check("miss_data", instr, data);
        check("miss_stall", stall, 0);
        check("miss_ce_end", ROM_CE, 1);
        check("miss_busreq_end", bus_req, 0);
      end else begin
        check("miss_pending_valid", instr_valid, 0);
        check("miss_pending_stall", stall, 1);
      end
      if (c == 0) begin
        check("miss_idle_ce", ROM_CE, 1);
        check("miss_idle_oe", ROM_OE, 1);
        check("miss_idle_busreq", bus_req, 0);
      end
      if (c >= 1 && c < v) check("miss_busreq", bus_req, 1);
      if (c == s) check("miss_setup_ce", ROM_CE, 1);
      if (c > s && c < v) begin
        check("miss_ce_low", ROM_CE, 0);
        check("miss_oe_low", ROM_OE, 0);
        check("miss_addr", rom_addr_o, addr);
      end
      @(posedge clk); #1;
    end
    m_v    = 1'b1;
    m_tag  = addr;
    m_data = data;
  endtask

  task automatic hit_txn(input logic [15:0] addr);
    pc        = addr;
    fetch_req = 1'b1;
    flush     = 1'b0;
    bus_grant = 1'($urandom);
    rom_data  = 16'($urandom);
    @(negedge clk);
    check("hit_valid", instr_valid, 1);
    check("hit_data", instr, m_data);
    check("hit_stall", stall, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    pc        = 16'($urandom);
    fetch_req = 1'b0;
    flush     = 1'b0;
    bus_grant = 1'b1;
    rom_data  = 16'($urandom);
    @(negedge clk);
    check("idle_valid", instr_valid, 0);
    check("idle_busreq", bus_req, 0);
    check("idle_ce", ROM_CE, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    int          pf_seen;

    rst = 1'b0; fetch_req = 1'b0; flush = 1'b0; bus_grant = 1'b0;
    pc = '0; rom_data = '0;
    m_v = 1'b0; m_tag = '0; m_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ce", ROM_CE, 1);
    check("rst_oe", ROM_OE, 1);
    check("rst_busreq", bus_req, 0);
    check("rst_addr", rom_addr_o, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;

`ifdef IFETCH_PREFETCH_EN
    // Fill 0xFFFF, then watch the speculative access to 0x0000 and hit it with no stall.
    set_grant(0);
    run_miss(16'hFFFF, 16'hBEEF);
    pf_seen = 0;
    for (int c = 0; c < WS + 5; c++) begin
      pc = 16'h1234; fetch_req = 1'b0; flush = 1'b0; bus_grant = 1'b1; rom_data = 16'h5A5A;
      @(negedge clk);
      if (bus_req && !ROM_CE && rom_addr_o == 16'h0000) pf_seen++;
      @(posedge clk); #1;
    end
    check("pf_issued", pf_seen, WS + 1);
    m_tag  = 16'h0000;
    m_data = 16'h5A5A;
    hit_txn(16'h0000);
    m_tag  = 16'hFFFF;
    m_data = 16'hBEEF;
    hit_txn(16'hFFFF);
`else
    // Basic miss with grant tied high, then an immediate re-request hits.
    set_grant(0);
    run_miss(16'h0040, 16'h1234);
    hit_txn(16'h0040);

    // Grant withheld 4 SETUP cycles, then dropped in the first WAIT cycle.
    set_grant(2);
    run_miss(16'h0200, 16'hA5C3);
    hit_txn(16'h0200);

    // Flush in the second WAIT cycle of a miss; the previously buffered line must be gone.
    for (int c = 0; c <= 3; c++) begin
      pc = 16'h0300; fetch_req = 1'b1; bus_grant = 1'b1;
      flush = (c == 3); rom_data = 16'($urandom);
      @(negedge clk);
      if (c >= 2) check("flush_wait_ce", ROM_CE, 0);
      @(posedge clk); #1;
    end
    m_v = 1'b0;
    set_grant(0);
    run_miss(16'h0200, 16'h0F0F);

    // Reset held for 2 cycles while an access is in WAIT.
    for (int c = 0; c <= 3; c++) begin
      pc = (c == 3) ? 16'h0200 : 16'h0500;
      fetch_req = 1'b1; flush = 1'b0; bus_grant = 1'b1; rom_data = 16'($urandom);
      rst = (c < 2);
      @(negedge clk);
      if (c == 3) begin
        check("rstw_ce", ROM_CE, 1);
        check("rstw_oe", ROM_OE, 1);
        check("rstw_busreq", bus_req, 0);
        check("rstw_valid", instr_valid, 0);
        check("rstw_instr", instr, 0);
        check("rstw_addr", rom_addr_o, 0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    m_v = 1'b0;
    run_miss(16'h0200, 16'h7777);

    // No speculative bus traffic after a fill.
    for (int i = 0; i < 20; i++) idle_cycle();

    // Randomized fetch stream.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'h0040;
        1:       a = 16'h0041;
        2:       a = 16'hFFFF;
        3:       a = m_tag;
        default: a = 16'($urandom);
      endcase
      if (m_v && m_tag == a) begin
        hit_txn(a);
      end else begin
        set_grant(1);
        run_miss(a, 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
